// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the CPU pipeline and the stall/flush controller.
// The pipeline side uses the master modport; the controller uses slave.
interface pipe_stall_ctrl_if #(
    parameter int NSTAGE = 6,
    parameter int CNT_W  = 6,
    parameter int ADDR_W = 32,
    parameter int PERF_W = 32
);
    logic [NSTAGE-1:0] stallreq_i;
    logic              mc_start_i;
    logic [CNT_W-1:0]  mc_cycles_i;
    logic              flush_req_i;
    logic [ADDR_W-1:0] flush_pc_i;
    logic [NSTAGE-1:0] stall_o;
    logic              flush_o;
    logic [ADDR_W-1:0] new_pc_o;
    logic              mc_busy_o;
    logic              mc_done_o;
    logic [PERF_W-1:0] stall_cycles_o;

    modport master (
        output stallreq_i, mc_start_i, mc_cycles_i, flush_req_i, flush_pc_i,
        input  stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o, stall_cycles_o
    );

    modport slave (
        input  stallreq_i, mc_start_i, mc_cycles_i, flush_req_i, flush_pc_i,
        output stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o, stall_cycles_o
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: stall vector from per-stage requests,
// multi-cycle EX sequencer, flush with redirect PC and stall-cycle counter.
module pipe_stall_ctrl #(
    parameter int NSTAGE   = 6,
    parameter int MC_STAGE = 3,
    parameter int CNT_W    = 6,
    parameter int ADDR_W   = 32,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PERF_W-1:0] r_perf;
    logic              w_mc_hold;
    logic              w_done;
    logic [NSTAGE-1:0] w_req;
    logic [NSTAGE-1:0] w_stall_raw;
    logic [NSTAGE-1:0] w_stall;
    logic              w_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_perf  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall[0])
                r_perf <= r_perf + PERF_W'(1);
        end
    end

    // Sequencer: hold EX while the counter is above one, release on the done cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mc_hold   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mc_start_i) begin
                    w_mc_hold = 1'b1;
                    if (!bus.flush_req_i) begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = (bus.mc_cycles_i == '0) ? CNT_W'(1) : bus.mc_cycles_i;
                    end
                end
            end
            S_BUSY: begin
                w_mc_hold = (r_cnt > CNT_W'(1));
                if (bus.flush_req_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Every stage at or below the highest requester holds; the one above gets a bubble.
    always_comb begin
        w_req           = bus.stallreq_i;
        w_req[MC_STAGE] = w_req[MC_STAGE] | w_mc_hold;
        w_acc           = 1'b0;
        w_stall_raw     = '0;
        for (int j = NSTAGE - 1; j >= 0; j--) begin
            w_acc          = w_acc | w_req[j];
            w_stall_raw[j] = w_acc;
        end
        w_stall = bus.flush_req_i ? '0 : w_stall_raw;
    end

    always_comb begin
        bus.stall_o        = rst ? '0 : w_stall;
        bus.flush_o        = !rst && bus.flush_req_i;
        bus.new_pc_o       = (!rst && bus.flush_req_i) ? bus.flush_pc_i : '0;
        bus.mc_busy_o      = !rst && (r_state == S_BUSY);
        bus.mc_done_o      = !rst && w_done;
        bus.stall_cycles_o = rst ? '0 : r_perf;
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a per-cycle vector table plus
// hand-written reset, counter-wrap and mid-operation reset sequences.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.PERF_W(32)) u_if ();
    pipe_stall_ctrl_if #(.PERF_W(4))  u_if4 ();

    assign u_if4.stallreq_i  = u_if.stallreq_i;
    assign u_if4.mc_start_i  = u_if.mc_start_i;
    assign u_if4.mc_cycles_i = u_if.mc_cycles_i;
    assign u_if4.flush_req_i = u_if.flush_req_i;
    assign u_if4.flush_pc_i  = u_if.flush_pc_i;

    pipe_stall_ctrl #(.PERF_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    pipe_stall_ctrl #(.PERF_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (u_if4.slave)
    );

    typedef struct {
        logic [5:0]  req;
        logic        start;
        logic [5:0]  n;
        logic        fl;
        logic [31:0] pc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_perf;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge, leaving half a period before sampling.
    task automatic drive(input logic [5:0] req, input logic start, input logic [5:0] n,
                         input logic fl, input logic [31:0] pc);
        @(posedge clk);
        #1;
        u_if.stallreq_i  = req;
        u_if.mc_start_i  = start;
        u_if.mc_cycles_i = n;
        u_if.flush_req_i = fl;
        u_if.flush_pc_i  = pc;
        #5;
    endtask

    task automatic chk_all(input string tag, input logic [5:0] st, input logic fo,
                           input logic [31:0] npc, input logic bz, input logic dn,
                           input logic [31:0] pf);
        chk({tag, ".stall"}, 32'(u_if.stall_o), 32'(st));
        chk({tag, ".flush"}, 32'(u_if.flush_o), 32'(fo));
        chk({tag, ".new_pc"}, u_if.new_pc_o, npc);
        chk({tag, ".busy"}, 32'(u_if.mc_busy_o), 32'(bz));
        chk({tag, ".done"}, 32'(u_if.mc_done_o), 32'(dn));
        chk({tag, ".perf"}, u_if.stall_cycles_o, pf);
    endtask

    task automatic sv(input int i, input logic [5:0] req, input logic start, input logic [5:0] n,
                      input logic fl, input logic [31:0] pc, input logic [5:0] es,
                      input logic ef, input logic [31:0] ep, input logic eb,
                      input logic ed, input logic [31:0] epf);
        vecs[i] = '{req, start, n, fl, pc, es, ef, ep, eb, ed, epf};
    endtask

    initial begin
        //  idx req      st n   fl pc            stall    fo npc           bz dn perf
        sv(0,  6'b000000, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, 0);
        sv(1,  6'b000100, 0, 0, 0, 32'h0,        6'b000111, 0, 32'h0,        0, 0, 0);
        sv(2,  6'b001100, 0, 0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 0, 1);
        sv(3,  6'b000001, 0, 0, 0, 32'h0,        6'b000001, 0, 32'h0,        0, 0, 2);
        sv(4,  6'b000000, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, 3);
        sv(5,  6'b000000, 1, 3, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 0, 3);
        sv(6,  6'b000000, 1, 7, 0, 32'h0,        6'b001111, 0, 32'h0,        1, 0, 4);
        sv(7,  6'b000000, 0, 0, 0, 32'h0,        6'b001111, 0, 32'h0,        1, 0, 5);
        sv(8,  6'b000000, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        1, 1, 6);
        sv(9,  6'b000000, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, 6);
        sv(10, 6'b000000, 1, 5, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 0, 6);
        sv(11, 6'b000000, 0, 0, 0, 32'h0,        6'b001111, 0, 32'h0,        1, 0, 7);
        sv(12, 6'b000000, 0, 0, 1, 32'hBFC00380, 6'b000000, 1, 32'hBFC00380, 1, 0, 8);
        sv(13, 6'b000000, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, 8);
        sv(14, 6'b000000, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, 8);
        sv(15, 6'b000000, 1, 2, 1, 32'h80000000, 6'b000000, 1, 32'h80000000, 0, 0, 8);
        sv(16, 6'b000000, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, 8);
        sv(17, 6'b000000, 1, 0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 0, 8);
        sv(18, 6'b010000, 0, 0, 0, 32'h0,        6'b011111, 0, 32'h0,        1, 1, 9);
        sv(19, 6'b000000, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, 10);

        rst              = 1'b1;
        u_if.stallreq_i  = 6'b001000;
        u_if.mc_start_i  = 1'b1;
        u_if.mc_cycles_i = 6'd4;
        u_if.flush_req_i = 1'b1;
        u_if.flush_pc_i  = 32'hDEADBEEF;

        // Reset held for two cycles with live requests: every output stays low.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #6;
            chk_all($sformatf("rst%0d", c), 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        u_if.stallreq_i  = '0;
        u_if.mc_start_i  = 1'b0;
        u_if.mc_cycles_i = '0;
        u_if.flush_req_i = 1'b0;
        u_if.flush_pc_i  = '0;
        #5;
        chk_all("post_rst", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].req, vecs[i].start, vecs[i].n, vecs[i].fl, vecs[i].pc);
            chk_all($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_pc,
                    vecs[i].e_busy, vecs[i].e_done, vecs[i].e_perf);
        end

        // Counter wrap on the 4-bit instance: 17 stalled cycles from zero end at 1.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 17; c++)
            drive(6'b000100, 1'b0, 6'd0, 1'b0, 32'h0);
        drive(6'b000000, 1'b0, 6'd0, 1'b0, 32'h0);
        chk("wrap.perf4", 32'(u_if4.stall_cycles_o), 32'd1);
        chk("wrap.perf32", u_if.stall_cycles_o, 32'd17);

        // Reset in the middle of a long operation.
        drive(6'b000000, 1'b1, 6'd10, 1'b0, 32'h0);
        drive(6'b000000, 1'b0, 6'd0, 1'b0, 32'h0);
        chk("midrst.busy_before", 32'(u_if.mc_busy_o), 32'd1);
        chk("midrst.stall_before", 32'(u_if.stall_o), 32'(6'b001111));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #5;
        chk_all("midrst.during", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #5;
        chk_all("midrst.after", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("midrst.perf4", 32'(u_if4.stall_cycles_o), 32'd0);
        drive(6'b000000, 1'b0, 6'd0, 1'b0, 32'h0);
        chk("midrst.idle_busy", 32'(u_if.mc_busy_o), 32'd0);
        chk("midrst.idle_done", 32'(u_if.mc_done_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
